serial_addsub: RTL



---
 rtl/serial_addsub_if.sv | 25 ++
 rtl/serial_addsub.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// Handshake and data bundle for the bit-serial adder/subtractor.
// The requester drives the operands; the unit returns the result and flags.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice with a registered carry,
// LSB first over WIDTH cycles; subtraction is a + ~b + 1.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] opa_r, opa_s, opb_r, opb_s, acc_r, acc_s, result_r, result_s;
  logic [CW-1:0]    bitcnt_r, bitcnt_s;
  logic             carry_r, carry_s, mode_r, mode_s;
  logic             busy_r, busy_s, done_r, done_s, cout_r, cout_s, ovf_r, ovf_s;
  logic             sum_s, carry_next_s;

  // Next-state, datapath and flag computation.
  always_comb begin
    state_s      = state_r;
    opa_s        = opa_r;
    opb_s        = opb_r;
    acc_s        = acc_r;
    result_s     = result_r;
    bitcnt_s     = bitcnt_r;
    carry_s      = carry_r;
    mode_s       = mode_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    cout_s       = cout_r;
    ovf_s        = ovf_r;
    sum_s        = fa_sum(opa_r[0], opb_r[0], carry_r);
    carry_next_s = fa_carry(opa_r[0], opb_r[0], carry_r);
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          opa_s    = bus.a;
          opb_s    = bus.sub ? ~bus.b : bus.b;
          carry_s  = bus.sub;
          mode_s   = bus.sub;
          bitcnt_s = '0;
          busy_s   = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        opa_s    = {1'b0, opa_r[WIDTH-1:1]};
        opb_s    = {1'b0, opb_r[WIDTH-1:1]};
        acc_s    = {sum_s, acc_r[WIDTH-1:1]};
        carry_s  = carry_next_s;
        bitcnt_s = bitcnt_r + CW'(1);
        if (bitcnt_r == LAST) begin
          // carry_r here is the carry into the MSB, so it decides signed overflow
          result_s = {sum_s, acc_r[WIDTH-1:1]};
          cout_s   = mode_r ? ~carry_next_s : carry_next_s;
          ovf_s    = carry_r ^ carry_next_s;
          done_s   = 1'b1;
          busy_s   = 1'b0;
          state_s  = IDLE;
        end else begin
          state_s  = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_r    <= '0;
      opb_r    <= '0;
      acc_r    <= '0;
      result_r <= '0;
      bitcnt_r <= '0;
      carry_r  <= 1'b0;
      mode_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      opa_r    <= opa_s;
      opb_r    <= opb_s;
      acc_r    <= acc_s;
      result_r <= result_s;
      bitcnt_r <= bitcnt_s;
      carry_r  <= carry_s;
      mode_r   <= mode_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      cout_r   <= cout_s;
      ovf_r    <= ovf_s;
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.cout   = cout_r;
  assign bus.ovf    = ovf_r;
endmodule
